// File: rtl/correlate_tmux.sv
// ============================================================================
//  correlate_tmux : time-multiplexed 1-bit complex correlator, TRATE slots
//  Revision: 1.0
// ============================================================================
`default_nettype none

module correlate_tmux #(
    parameter int WIDTH    = 8,
    parameter int TRATE    = 12,
    parameter int TBITS    = 4,
    parameter int SATURATE = 1
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    valid_i,
    input  logic                    first_i,
    input  logic                    last_i,
    input  logic                    auto_i,
    input  logic [TBITS-1:0]        taddr_i,
    input  logic                    ai_i,
    input  logic                    aq_i,
    input  logic                    bi_i,
    input  logic                    bq_i,
    output logic                    valid_o,
    output logic [TBITS-1:0]        taddr_o,
    output logic signed [WIDTH-1:0] re_o,
    output logic signed [WIDTH-1:0] im_o,
    output logic                    sat_o
);

    localparam logic [TBITS:0]        C_TRATE = TRATE[TBITS:0];
    localparam logic signed [WIDTH-1:0] C_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic signed [WIDTH-1:0] C_MIN = {1'b1, {(WIDTH-1){1'b0}}};

    // Stage 1 registers
    logic             s1_valid_q, s1_valid_d;
    logic             s1_first_q, s1_first_d;
    logic             s1_last_q,  s1_last_d;
    logic [TBITS-1:0] s1_taddr_q, s1_taddr_d;
    logic signed [2:0] s1_re_q, s1_re_d;
    logic signed [2:0] s1_im_q, s1_im_d;

    // Slot state and output registers
    logic signed [WIDTH-1:0] acc_re_q [TRATE];
    logic signed [WIDTH-1:0] acc_re_d [TRATE];
    logic signed [WIDTH-1:0] acc_im_q [TRATE];
    logic signed [WIDTH-1:0] acc_im_d [TRATE];
    logic                    sat_q    [TRATE];
    logic                    sat_d    [TRATE];
    logic                    valid_o_q, valid_o_d;
    logic [TBITS-1:0]        taddr_o_q, taddr_o_d;
    logic signed [WIDTH-1:0] re_o_q, re_o_d;
    logic signed [WIDTH-1:0] im_o_q, im_o_d;
    logic                    sat_o_q, sat_o_d;

    logic signed [WIDTH-1:0] w_base_re, w_base_im, w_new_re, w_new_im;
    logic signed [WIDTH:0]   w_sum_re, w_sum_im;
    logic                    w_ovf_re, w_ovf_im, w_sat_new;

    // Stage 1: step computation; an XOR of sign bits is a product of +/-1 values
    always_comb begin
        s1_valid_d = valid_i && ({1'b0, taddr_i} < C_TRATE);
        s1_first_d = first_i;
        s1_last_d  = last_i;
        s1_taddr_d = taddr_i;
        s1_re_d    = 3'sd0;
        s1_im_d    = 3'sd0;
        if (auto_i) begin
            s1_re_d = ai_i ? -3'sd1 : 3'sd1;
            s1_im_d = aq_i ? -3'sd1 : 3'sd1;
        end else begin
            case ({ai_i ^ bi_i, aq_i ^ bq_i})
                2'b00:   s1_re_d = 3'sd2;
                2'b11:   s1_re_d = -3'sd2;
                default: s1_re_d = 3'sd0;
            endcase
            case ({aq_i ^ bi_i, ai_i ^ bq_i})
                2'b01:   s1_im_d = 3'sd2;
                2'b10:   s1_im_d = -3'sd2;
                default: s1_im_d = 3'sd0;
            endcase
        end
    end

    // Stage 2: single-cycle read-modify-write, so same-slot samples chain at full rate
    always_comb begin
        acc_re_d  = acc_re_q;
        acc_im_d  = acc_im_q;
        sat_d     = sat_q;
        valid_o_d = 1'b0;
        taddr_o_d = taddr_o_q;
        re_o_d    = re_o_q;
        im_o_d    = im_o_q;
        sat_o_d   = sat_o_q;
        w_base_re = s1_first_q ? '0 : acc_re_q[s1_taddr_q];
        w_base_im = s1_first_q ? '0 : acc_im_q[s1_taddr_q];
        w_sum_re  = {w_base_re[WIDTH-1], w_base_re} + {{(WIDTH-2){s1_re_q[2]}}, s1_re_q};
        w_sum_im  = {w_base_im[WIDTH-1], w_base_im} + {{(WIDTH-2){s1_im_q[2]}}, s1_im_q};
        w_ovf_re  = w_sum_re[WIDTH] ^ w_sum_re[WIDTH-1];
        w_ovf_im  = w_sum_im[WIDTH] ^ w_sum_im[WIDTH-1];
        w_new_re  = w_sum_re[WIDTH-1:0];
        w_new_im  = w_sum_im[WIDTH-1:0];
        if (SATURATE != 0 && w_ovf_re) w_new_re = w_sum_re[WIDTH] ? C_MIN : C_MAX;
        if (SATURATE != 0 && w_ovf_im) w_new_im = w_sum_im[WIDTH] ? C_MIN : C_MAX;
        w_sat_new = (s1_first_q ? 1'b0 : sat_q[s1_taddr_q]) | w_ovf_re | w_ovf_im;
        if (s1_valid_q) begin
            acc_re_d[s1_taddr_q] = w_new_re;
            acc_im_d[s1_taddr_q] = w_new_im;
            sat_d[s1_taddr_q]    = w_sat_new;
            if (s1_last_q) begin
                valid_o_d = 1'b1;
                taddr_o_d = s1_taddr_q;
                re_o_d    = w_new_re;
                im_o_d    = w_new_im;
                sat_o_d   = w_sat_new;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            s1_valid_q <= 1'b0;
            s1_first_q <= 1'b0;
            s1_last_q  <= 1'b0;
            s1_taddr_q <= '0;
            s1_re_q    <= '0;
            s1_im_q    <= '0;
            for (int i = 0; i < TRATE; i++) begin
                acc_re_q[i] <= '0;
                acc_im_q[i] <= '0;
                sat_q[i]    <= 1'b0;
            end
            valid_o_q  <= 1'b0;
            taddr_o_q  <= '0;
            re_o_q     <= '0;
            im_o_q     <= '0;
            sat_o_q    <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_first_q <= s1_first_d;
            s1_last_q  <= s1_last_d;
            s1_taddr_q <= s1_taddr_d;
            s1_re_q    <= s1_re_d;
            s1_im_q    <= s1_im_d;
            acc_re_q   <= acc_re_d;
            acc_im_q   <= acc_im_d;
            sat_q      <= sat_d;
            valid_o_q  <= valid_o_d;
            taddr_o_q  <= taddr_o_d;
            re_o_q     <= re_o_d;
            im_o_q     <= im_o_d;
            sat_o_q    <= sat_o_d;
        end
    end

    assign valid_o = valid_o_q;
    assign taddr_o = taddr_o_q;
    assign re_o    = re_o_q;
    assign im_o    = im_o_q;
    assign sat_o   = sat_o_q;

endmodule

`default_nettype wire

// File: tb/tb_correlate_tmux.sv
// ============================================================================
//  tb_correlate_tmux : directed self-checking bench for correlate_tmux
//  Revision: 1.0
// ============================================================================
`default_nettype none

module tb_correlate_tmux;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic       reset_n, valid_i, first_i, last_i, auto_i, ai_i, aq_i, bi_i, bq_i;
    logic [3:0] taddr_i;

    logic       v8, v4s, v4w;
    logic [3:0] t8, t4s, t4w;
    logic [7:0] re8, im8;
    logic [3:0] re4s, im4s, re4w, im4w;
    logic       s8, s4s, s4w;

    correlate_tmux #(.WIDTH(8), .TRATE(12), .TBITS(4), .SATURATE(1)) u8 (
        .clock(clock), .reset_n(reset_n), .valid_i(valid_i), .first_i(first_i),
        .last_i(last_i), .auto_i(auto_i), .taddr_i(taddr_i), .ai_i(ai_i), .aq_i(aq_i),
        .bi_i(bi_i), .bq_i(bq_i), .valid_o(v8), .taddr_o(t8), .re_o(re8), .im_o(im8),
        .sat_o(s8));

    correlate_tmux #(.WIDTH(4), .TRATE(12), .TBITS(4), .SATURATE(1)) u4s (
        .clock(clock), .reset_n(reset_n), .valid_i(valid_i), .first_i(first_i),
        .last_i(last_i), .auto_i(auto_i), .taddr_i(taddr_i), .ai_i(ai_i), .aq_i(aq_i),
        .bi_i(bi_i), .bq_i(bq_i), .valid_o(v4s), .taddr_o(t4s), .re_o(re4s), .im_o(im4s),
        .sat_o(s4s));

    correlate_tmux #(.WIDTH(4), .TRATE(12), .TBITS(4), .SATURATE(0)) u4w (
        .clock(clock), .reset_n(reset_n), .valid_i(valid_i), .first_i(first_i),
        .last_i(last_i), .auto_i(auto_i), .taddr_i(taddr_i), .ai_i(ai_i), .aq_i(aq_i),
        .bi_i(bi_i), .bq_i(bq_i), .valid_o(v4w), .taddr_o(t4w), .re_o(re4w), .im_o(im4w),
        .sat_o(s4w));

    typedef struct {
        int t;
        int re;
        int im;
        int sat;
        int cyc;
    } res_t;

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    res_t q8[$];
    res_t q4s[$];
    res_t q4w[$];
    int   lastq[$];
    res_t mr;

    // Inputs change at posedge+1, so the negedge sees stable inputs and outputs
    always @(negedge clock) begin
        cyc = cyc + 1;
        if (valid_i === 1'b1 && last_i === 1'b1 && reset_n === 1'b1) lastq.push_back(cyc);
        if (v8 === 1'b1) begin
            mr.t = int'(t8); mr.re = int'($signed(re8)); mr.im = int'($signed(im8));
            mr.sat = int'(s8); mr.cyc = cyc;
            q8.push_back(mr);
        end
        if (v4s === 1'b1) begin
            mr.t = int'(t4s); mr.re = int'($signed(re4s)); mr.im = int'($signed(im4s));
            mr.sat = int'(s4s); mr.cyc = cyc;
            q4s.push_back(mr);
        end
        if (v4w === 1'b1) begin
            mr.t = int'(t4w); mr.re = int'($signed(re4w)); mr.im = int'($signed(im4w));
            mr.sat = int'(s4w); mr.cyc = cyc;
            q4w.push_back(mr);
        end
    end

    function automatic res_t nores();
        res_t r;
        r.t = -1; r.re = -999; r.im = -999; r.sat = -1; r.cyc = -1;
        return r;
    endfunction

    task automatic clear_q();
        q8.delete(); q4s.delete(); q4w.delete(); lastq.delete();
    endtask

    task automatic send(input logic f, input logic l, input logic au, input logic [3:0] t,
                        input logic a_i, input logic a_q, input logic b_i, input logic b_q);
        @(posedge clock); #1;
        valid_i = 1'b1; first_i = f; last_i = l; auto_i = au; taddr_i = t;
        ai_i = a_i; aq_i = a_q; bi_i = b_i; bq_i = b_q;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clock); #1;
            valid_i = 1'b0; first_i = 1'b0; last_i = 1'b0; auto_i = 1'b0;
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        idle(3);
        total++; if ({v8, t8, re8, im8, s8} !== 21'd0) begin
            bad++; $display("FAIL reset_w8 got v=%b t=%0d re=%0d im=%0d sat=%b want all 0", v8, t8, re8, im8, s8);
        end
        total++; if ({v4s, t4s, re4s, im4s, s4s, v4w, t4w, re4w, im4w, s4w} !== 28'd0) begin
            bad++; $display("FAIL reset_w4 got re_s=%0d re_w=%0d sat_s=%b sat_w=%b want all 0", re4s, re4w, s4s, s4w);
        end
        reset_n = 1'b1;
        idle(2);
    endtask

    task automatic test_cross_sum();
        res_t r;
        clear_q();
        send(1, 0, 0, 4'd3, 0, 0, 0, 0);
        send(0, 0, 0, 4'd3, 0, 0, 0, 0);
        send(0, 1, 0, 4'd3, 0, 0, 0, 0);
        idle(5);
        r = (q8.size() > 0) ? q8[0] : nores();
        total++; if (q8.size() !== 1) begin
            bad++; $display("FAIL cross_count got=%0d want=1", q8.size());
        end
        total++; if (r.t !== 3 || r.re !== 6 || r.im !== 0 || r.sat !== 0) begin
            bad++; $display("FAIL cross_value got t=%0d re=%0d im=%0d sat=%0d want t=3 re=6 im=0 sat=0", r.t, r.re, r.im, r.sat);
        end
        total++; if (lastq.size() < 1 || r.cyc - lastq[0] !== 2) begin
            bad++; $display("FAIL cross_latency got=%0d want=2", (lastq.size() > 0) ? r.cyc - lastq[0] : -1);
        end
    endtask

    task automatic test_imag();
        res_t r;
        clear_q();
        send(1, 1, 0, 4'd0, 0, 0, 0, 1);
        idle(5);
        r = (q8.size() == 1) ? q8[0] : nores();
        total++; if (r.t !== 0 || r.re !== 0 || r.im !== 2 || r.sat !== 0) begin
            bad++; $display("FAIL imag_sign got t=%0d re=%0d im=%0d sat=%0d want t=0 re=0 im=2 sat=0", r.t, r.re, r.im, r.sat);
        end
    endtask

    task automatic test_saturation();
        res_t rs, rw, r8;
        clear_q();
        send(1, 0, 0, 4'd2, 0, 0, 0, 0);
        send(0, 0, 0, 4'd2, 0, 0, 0, 0);
        send(0, 0, 0, 4'd2, 0, 0, 0, 0);
        send(0, 1, 0, 4'd2, 0, 0, 0, 0);
        idle(5);
        rs = (q4s.size() == 1) ? q4s[0] : nores();
        rw = (q4w.size() == 1) ? q4w[0] : nores();
        r8 = (q8.size() == 1) ? q8[0] : nores();
        total++; if (rs.re !== 7 || rs.sat !== 1) begin
            bad++; $display("FAIL sat_clamp got re=%0d sat=%0d want re=7 sat=1", rs.re, rs.sat);
        end
        total++; if (rw.re !== -8 || rw.sat !== 1) begin
            bad++; $display("FAIL sat_wrap got re=%0d sat=%0d want re=-8 sat=1", rw.re, rw.sat);
        end
        total++; if (r8.re !== 8 || r8.sat !== 0) begin
            bad++; $display("FAIL sat_wide got re=%0d sat=%0d want re=8 sat=0", r8.re, r8.sat);
        end
        clear_q();
        send(1, 1, 0, 4'd2, 0, 0, 0, 0);
        idle(5);
        rs = (q4s.size() == 1) ? q4s[0] : nores();
        rw = (q4w.size() == 1) ? q4w[0] : nores();
        total++; if (rs.re !== 2 || rs.sat !== 0 || rw.re !== 2 || rw.sat !== 0) begin
            bad++; $display("FAIL sat_cleared got clamp re=%0d sat=%0d wrap re=%0d sat=%0d want re=2 sat=0", rs.re, rs.sat, rw.re, rw.sat);
        end
    endtask

    task automatic test_auto();
        res_t r;
        clear_q();
        send(1, 0, 1, 4'd5, 0, 1, 1, 1);
        send(0, 0, 1, 4'd5, 0, 0, 1, 1);
        send(0, 1, 1, 4'd5, 1, 1, 1, 1);
        idle(5);
        r = (q8.size() == 1) ? q8[0] : nores();
        total++; if (r.t !== 5 || r.re !== 1 || r.im !== -1 || r.sat !== 0) begin
            bad++; $display("FAIL auto_mean got t=%0d re=%0d im=%0d sat=%0d want t=5 re=1 im=-1 sat=0", r.t, r.re, r.im, r.sat);
        end
    endtask

    task automatic test_interleave();
        int m_re[12];
        int m_im[12];
        int sai, saq, sbi, sbq;
        logic a_i, a_q, b_i, b_q;
        res_t r;
        clear_q();
        for (int rnd = 0; rnd < 3; rnd++) begin
            for (int s = 0; s < 12; s++) begin
                a_i = 1'($urandom % 2); a_q = 1'($urandom % 2);
                b_i = 1'($urandom % 2); b_q = 1'($urandom % 2);
                sai = a_i ? -1 : 1; saq = a_q ? -1 : 1;
                sbi = b_i ? -1 : 1; sbq = b_q ? -1 : 1;
                if (rnd == 0) begin
                    m_re[s] = 0; m_im[s] = 0;
                end
                m_re[s] = m_re[s] + sai * sbi + saq * sbq;
                m_im[s] = m_im[s] + saq * sbi - sai * sbq;
                send(rnd == 0, rnd == 2, 0, 4'(s), a_i, a_q, b_i, b_q);
            end
        end
        idle(5);
        total++; if (q8.size() !== 12) begin
            bad++; $display("FAIL interleave_count got=%0d want=12", q8.size());
        end
        for (int s = 0; s < 12; s++) begin
            r = (q8.size() > s) ? q8[s] : nores();
            total++; if (r.t !== s || r.re !== m_re[s] || r.im !== m_im[s] || r.sat !== 0) begin
                bad++; $display("FAIL interleave_slot%0d got t=%0d re=%0d im=%0d sat=%0d want t=%0d re=%0d im=%0d sat=0",
                                s, r.t, r.re, r.im, r.sat, s, m_re[s], m_im[s]);
            end
        end
    endtask

    task automatic test_back_to_back();
        res_t r0, r1;
        clear_q();
        send(1, 0, 0, 4'd4, 0, 0, 0, 0);
        send(0, 0, 0, 4'd4, 0, 0, 0, 1);
        send(0, 1, 0, 4'd4, 1, 0, 0, 0);
        send(1, 1, 0, 4'd4, 1, 1, 0, 0);
        idle(5);
        r0 = (q8.size() == 2) ? q8[0] : nores();
        r1 = (q8.size() == 2) ? q8[1] : nores();
        total++; if (r0.t !== 4 || r0.re !== 2 || r0.im !== 4 || r0.sat !== 0) begin
            bad++; $display("FAIL b2b_frame got t=%0d re=%0d im=%0d sat=%0d want t=4 re=2 im=4 sat=0", r0.t, r0.re, r0.im, r0.sat);
        end
        total++; if (r1.t !== 4 || r1.re !== -2 || r1.im !== 0 || r1.cyc - r0.cyc !== 1) begin
            bad++; $display("FAIL b2b_next got t=%0d re=%0d im=%0d gap=%0d want t=4 re=-2 im=0 gap=1", r1.t, r1.re, r1.im, r1.cyc - r0.cyc);
        end
    endtask

    task automatic test_drop();
        clear_q();
        send(1, 1, 0, 4'd13, 0, 0, 0, 0);
        idle(5);
        total++; if (q8.size() !== 0 || q4s.size() !== 0) begin
            bad++; $display("FAIL drop_taddr13 got results=%0d want=0", q8.size());
        end
    endtask

    task automatic test_reset_mid();
        clear_q();
        send(1, 1, 0, 4'd6, 0, 0, 0, 0);
        @(posedge clock); #1;
        reset_n = 1'b0; valid_i = 1'b0; first_i = 1'b0; last_i = 1'b0;
        @(posedge clock); #1;
        reset_n = 1'b1;
        idle(5);
        total++; if (q8.size() !== 0) begin
            bad++; $display("FAIL reset_mid_emit got results=%0d want=0", q8.size());
        end
        total++; if ({v8, t8, re8, im8, s8} !== 21'd0) begin
            bad++; $display("FAIL reset_mid_outs got v=%b t=%0d re=%0d im=%0d sat=%b want all 0", v8, t8, re8, im8, s8);
        end
    endtask

    task automatic test_no_first();
        res_t r;
        clear_q();
        send(0, 0, 0, 4'd7, 0, 0, 0, 0);
        send(0, 1, 0, 4'd7, 0, 0, 0, 0);
        idle(5);
        r = (q8.size() == 1) ? q8[0] : nores();
        total++; if (r.t !== 7 || r.re !== 4 || r.im !== 0 || r.sat !== 0) begin
            bad++; $display("FAIL no_first got t=%0d re=%0d im=%0d sat=%0d want t=7 re=4 im=0 sat=0", r.t, r.re, r.im, r.sat);
        end
    endtask

    initial begin
        reset_n = 1'b0; valid_i = 1'b0; first_i = 1'b0; last_i = 1'b0; auto_i = 1'b0;
        taddr_i = 4'd0; ai_i = 1'b0; aq_i = 1'b0; bi_i = 1'b0; bq_i = 1'b0;
        test_reset();
        test_cross_sum();
        test_imag();
        test_saturation();
        test_auto();
        test_interleave();
        test_back_to_back();
        test_drop();
        test_reset_mid();
        test_no_first();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
